// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per clock, LSB first.
// Ports: clk, rst_n (sync, active low), start, a, b -> busy, done, sum, cout.
// Optional SERIAL_ADDER_SUB_EN adds input sub: a - b with cout = borrow.
// Timing: accept at edge 0, RUN for WIDTH edges, DONE for one cycle
// (done=1), then IDLE; back-to-back period is WIDTH+2 cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sub_q;
    logic             sub_in;
    logic             accept;
    logic             last;
    logic             s_bit;
    logic             c_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt  = (a_sh[0] & b_sh[0]) |
                    (a_sh[0] & carry)   |
                    (b_sh[0] & carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b and preload the carry.
            a_sh  <= a;
            b_sh  <= sub_in ? ~b : b;
            carry <= sub_in;
            sub_q <= sub_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum   <= {s_bit, sum[WIDTH-1:1]};
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= c_nxt;
            cnt   <= cnt + CW'(1);
            // In subtract mode a missing final carry means a borrow.
            if (last) cout <= c_nxt ^ sub_q;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder (WIDTH=8)
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub_v = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_v),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic s);
        int r;
        logic [W:0] res;
        if (s) begin
            r = int'(x) - int'(y);
            res = {(x < y), W'(r)};
        end else begin
            r = int'(x) + int'(y);
            res = {(r > 255), W'(r)};
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s);
        a = x;
        b = y;
        sub_v = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub_v = 1'($urandom);
        chk(32'(busy), 32'd1, "busy_after_accept");
    endtask

    task automatic await_done(input logic [W-1:0] es, input logic ec,
                              input int glitch, input bit hold,
                              input string tag);
        int k = 0;
        int nbusy = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) nbusy++;
            if (k == glitch) begin
                start = 1'b1;
                a = 8'h11;
                b = 8'h22;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        if (busy === 1'b1) nbusy++;
        chk(32'(k), 32'(W), {tag, "_latency"});
        chk(32'(nbusy), 32'(W + 1), {tag, "_busy_cycles"});
        chk(32'(sum), 32'(es), {tag, "_sum"});
        chk(32'(cout), 32'(ec), {tag, "_cout"});
        if (!hold) begin
            tick();
            chk(32'(done), 32'd0, {tag, "_done_width"});
            chk(32'(busy), 32'd0, {tag, "_idle"});
            chk(32'(sum), 32'(es), {tag, "_sum_stable"});
        end
    endtask

    initial begin
        logic [W:0]   e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;

        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        chk(32'(busy), 32'd0, "reset_busy");
        chk(32'(done), 32'd0, "reset_done");
        chk(32'(sum), 32'd0, "reset_sum");
        chk(32'(cout), 32'd0, "reset_cout");
        start = 1'b0;

        rst_n = 1'b1;
        launch(8'h03, 8'h05, 1'b0);
        await_done(8'h08, 1'b0, -1, 1'b0, "add_3_5");

        launch(8'hFF, 8'h01, 1'b0);
        await_done(8'h00, 1'b1, -1, 1'b0, "wrap_ff_1");

        launch(8'h40, 8'h07, 1'b0);
        await_done(8'h47, 1'b0, 3, 1'b1, "ignore_start");
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        sub_v = 1'b0;
        tick();
        chk(32'(busy), 32'd0, "b2b_idle_gap");
        chk(32'(done), 32'd0, "b2b_done_low");
        tick();
        chk(32'(busy), 32'd1, "b2b_accepted");
        start = 1'b0;
        a = 8'hAA;
        b = 8'h55;
        await_done(8'h33, 1'b0, -1, 1'b0, "b2b_11_22");

        launch(8'h12, 8'h34, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
        tick();
        chk(32'(busy), 32'd0, "abort_busy");
        chk(32'(done), 32'd0, "abort_done");
        chk(32'(sum), 32'd0, "abort_sum");
        chk(32'(cout), 32'd0, "abort_cout");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (W + 3) begin
            tick();
            chk(32'(done), 32'd0, "abort_no_done");
        end
        launch(8'h12, 8'h34, 1'b0);
        await_done(8'h46, 1'b0, -1, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
        launch(8'h05, 8'h03, 1'b1);
        await_done(8'h02, 1'b0, -1, 1'b0, "sub_5_3");
        launch(8'h03, 8'h05, 1'b1);
        await_done(8'hFE, 1'b1, -1, 1'b0, "sub_3_5");
`endif

        for (int i = 0; i < 1000; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            if (i % 50 == 0) x = '1;
            if (i % 70 == 0) y = '0;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            e = model(x, y, s);
            launch(x, y, s);
            await_done(e[W-1:0], e[W], -1, 1'b0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
